// File: rtl/eip_redirect_ctrl.sv
// EIP update / front-end redirect sequencer: arbitrates WB redirects, interrupts and
// sequential decode advance, then offers the new fetch address and blocks refill.
module eip_redirect_ctrl #(
  parameter int REFILL_CYC = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_V_wb,
  input  logic              r_wb_eip_change,
  input  logic [ADDR_W-1:0] w_wb_target,
  input  logic              int_req,
  input  logic [ADDR_W-1:0] int_vector,
  output logic              int_ack,
  input  logic              r_V_de,
  input  logic              w_not_stall_fe,
  input  logic              w_de_br_stall,
  input  logic [ADDR_W-1:0] w_de_EIP_next,
  output logic [1:0]        ld_eip,
  output logic [ADDR_W-1:0] eip_nxt,
  output logic              flush_pipe,
  output logic              fe_redir_valid,
  input  logic              fe_redir_ready,
  output logic [ADDR_W-1:0] fe_redir_addr,
  output logic              fe_hold,
  output logic [1:0]        ctl_state
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_SEND   = 2'b01;
  localparam logic [1:0] S_REFILL = 2'b10;

  localparam int CNT_W = (REFILL_CYC < 2) ? 1 : $clog2(REFILL_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((REFILL_CYC > 0) ? (REFILL_CYC - 1) : 0);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pend;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_pend_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_wb_redir;
  logic              w_int_take;
  logic              w_event;
  logic              w_seq_ok;
  logic [ADDR_W-1:0] w_redir_addr;

  // WB redirects win everywhere; interrupts only start from IDLE.
  assign w_wb_redir   = r_V_wb & r_wb_eip_change;
  assign w_int_take   = int_req & ~w_wb_redir & (r_state == S_IDLE);
  assign w_event      = w_wb_redir | w_int_take;
  assign w_seq_ok     = r_V_de & w_not_stall_fe & ~w_de_br_stall;
  assign w_redir_addr = w_wb_redir ? w_wb_target : int_vector;
  assign ctl_state    = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    if (w_event) begin
      w_state_nxt = S_SEND;
      w_pend_nxt  = w_redir_addr;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_SEND: if (fe_redir_ready) begin
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = (REFILL_CYC == 0) ? S_IDLE : S_REFILL;
        end
        S_REFILL: begin
          if (r_cnt == '0) w_state_nxt = S_IDLE;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, independent of inputs.
  always_comb begin
    ld_eip         = 2'b00;
    eip_nxt        = w_de_EIP_next;
    flush_pipe     = 1'b0;
    int_ack        = 1'b0;
    fe_redir_valid = 1'b0;
    fe_redir_addr  = '0;
    fe_hold        = 1'b0;
    if (rst_n) begin
      fe_redir_addr = r_pend;
      if (w_event) begin
        ld_eip     = 2'b10;
        eip_nxt    = w_redir_addr;
        flush_pipe = 1'b1;
        int_ack    = w_int_take;
      end
      case (r_state)
        S_IDLE: if (!w_event) ld_eip = {1'b0, w_seq_ok};
        S_SEND: begin
          // A restart withdraws the stale offer so fetch can't take the old address.
          fe_redir_valid = ~w_wb_redir;
          fe_hold        = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eip_redirect_ctrl.sv
// Bench for eip_redirect_ctrl: per-cycle vector table, expected outputs queued when
// driven and compared mid-cycle, plus a randomized-backpressure redirect sequence.
module tb_eip_redirect_ctrl;
  localparam int AW = 32;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          r_V_wb, r_wb_eip_change, int_req, r_V_de, w_not_stall_fe, w_de_br_stall;
  logic          fe_redir_ready;
  logic [AW-1:0] w_wb_target, int_vector, w_de_EIP_next;
  logic          int_ack, flush_pipe, fe_redir_valid, fe_hold;
  logic [1:0]    ld_eip, ctl_state;
  logic [AW-1:0] eip_nxt, fe_redir_addr;

  eip_redirect_ctrl #(.REFILL_CYC(RC), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .r_V_wb(r_V_wb), .r_wb_eip_change(r_wb_eip_change),
    .w_wb_target(w_wb_target), .int_req(int_req), .int_vector(int_vector), .int_ack(int_ack),
    .r_V_de(r_V_de), .w_not_stall_fe(w_not_stall_fe), .w_de_br_stall(w_de_br_stall),
    .w_de_EIP_next(w_de_EIP_next), .ld_eip(ld_eip), .eip_nxt(eip_nxt), .flush_pipe(flush_pipe),
    .fe_redir_valid(fe_redir_valid), .fe_redir_ready(fe_redir_ready),
    .fe_redir_addr(fe_redir_addr), .fe_hold(fe_hold), .ctl_state(ctl_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm; logic rstn; logic [1:0] wb; logic [AW-1:0] tgt; logic irq; logic [AW-1:0] ivec;
    logic de; logic nsf; logic brs; logic [AW-1:0] enx; logic rdy;
    logic [1:0] ld; logic [AW-1:0] eip; logic fl; logic ack; logic val; logic [AW-1:0] addr;
    logic hold; logic [1:0] st;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(string nm, logic rstn, logic [1:0] wb, logic [AW-1:0] tgt,
      logic irq, logic [AW-1:0] ivec, logic de, logic nsf, logic brs, logic [AW-1:0] enx,
      logic rdy, logic [1:0] ld, logic [AW-1:0] eip, logic fl, logic ack, logic val,
      logic [AW-1:0] addr, logic hold, logic [1:0] st);
    vec_t v;
    v.nm = nm; v.rstn = rstn; v.wb = wb; v.tgt = tgt; v.irq = irq; v.ivec = ivec;
    v.de = de; v.nsf = nsf; v.brs = brs; v.enx = enx; v.rdy = rdy;
    v.ld = ld; v.eip = eip; v.fl = fl; v.ack = ack; v.val = val; v.addr = addr;
    v.hold = hold; v.st = st;
    return v;
  endfunction

  task automatic chk(string nm, string f, logic [AW-1:0] act, logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h expected=%h", nm, f, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    @(posedge clk);
    #1;
    rst_n = v.rstn; r_V_wb = v.wb[1]; r_wb_eip_change = v.wb[0]; w_wb_target = v.tgt;
    int_req = v.irq; int_vector = v.ivec; r_V_de = v.de; w_not_stall_fe = v.nsf;
    w_de_br_stall = v.brs; w_de_EIP_next = v.enx; fe_redir_ready = v.rdy;
    sb.push_back(v);
  endtask

  // Scoreboard drain: compare each queued expectation mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk(e.nm, "ld_eip", AW'(ld_eip), AW'(e.ld));
      chk(e.nm, "eip_nxt", eip_nxt, e.eip);
      chk(e.nm, "flush", AW'(flush_pipe), AW'(e.fl));
      chk(e.nm, "int_ack", AW'(int_ack), AW'(e.ack));
      chk(e.nm, "valid", AW'(fe_redir_valid), AW'(e.val));
      chk(e.nm, "addr", fe_redir_addr, e.addr);
      chk(e.nm, "hold", AW'(fe_hold), AW'(e.hold));
      chk(e.nm, "state", AW'(ctl_state), AW'(e.st));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    r_V_wb = 0; r_wb_eip_change = 0; w_wb_target = '0; int_req = 0; int_vector = '0;
    r_V_de = 0; w_not_stall_fe = 0; w_de_br_stall = 0; w_de_EIP_next = '0; fe_redir_ready = 0;
    #1 rst_n = 1'b0;

    //             name        rst wb     tgt      irq ivec     de nsf brs enx      rdy ld     eip      fl ack val addr     hold st
    tbl.push_back(mk("reset",   0, 2'b11, 32'h6000, 1, 32'h8000, 1, 1, 0, 32'h1004, 1, 2'b00, 32'h1004, 0, 0, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("seq",     1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b01, 32'h1004, 0, 0, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("brstall", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 1, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("festall", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 0, 0, 32'h1008, 0, 2'b00, 32'h1008, 0, 0, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("de_inv",  1, 2'b00, 32'h0000, 0, 32'h0000, 0, 1, 0, 32'h100c, 0, 2'b00, 32'h100c, 0, 0, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("wbnochg", 1, 2'b10, 32'h5555, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b01, 32'h1004, 0, 0, 0, 32'h0000, 0, 2'd0));
    // WB redirect, ready at T+1
    tbl.push_back(mk("wb_T",    1, 2'b11, 32'h2000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b10, 32'h2000, 1, 0, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("wb_T1",   1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 1, 2'b00, 32'h1004, 0, 0, 1, 32'h2000, 1, 2'd1));
    tbl.push_back(mk("wb_T2",   1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'h2000, 0, 2'd2));
    tbl.push_back(mk("wb_T3",   1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'h2000, 0, 2'd2));
    tbl.push_back(mk("wb_T4",   1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b01, 32'h1004, 0, 0, 0, 32'h2000, 0, 2'd0));
    // backpressure: ready low 3 cycles, accepted on the 4th
    tbl.push_back(mk("bp_T",    1, 2'b11, 32'h2000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b10, 32'h2000, 1, 0, 0, 32'h2000, 0, 2'd0));
    tbl.push_back(mk("bp_1",    1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 1, 32'h2000, 1, 2'd1));
    tbl.push_back(mk("bp_2",    1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 1, 32'h2000, 1, 2'd1));
    tbl.push_back(mk("bp_3",    1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 1, 32'h2000, 1, 2'd1));
    tbl.push_back(mk("bp_acc",  1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 1, 2'b00, 32'h1004, 0, 0, 1, 32'h2000, 1, 2'd1));
    tbl.push_back(mk("bp_rf1",  1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'h2000, 0, 2'd2));
    tbl.push_back(mk("bp_rf2",  1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'h2000, 0, 2'd2));
    tbl.push_back(mk("bp_idle", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b01, 32'h1004, 0, 0, 0, 32'h2000, 0, 2'd0));
    // collision, then restart inside SEND, then the held interrupt is taken in IDLE
    tbl.push_back(mk("col_T",   1, 2'b11, 32'h3000, 1, 32'h8000, 1, 1, 0, 32'h1004, 0, 2'b10, 32'h3000, 1, 0, 0, 32'h2000, 0, 2'd0));
    tbl.push_back(mk("col_snd", 1, 2'b00, 32'h0000, 1, 32'h8000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 1, 32'h3000, 1, 2'd1));
    tbl.push_back(mk("restart", 1, 2'b11, 32'h4000, 1, 32'h8000, 1, 1, 0, 32'h1004, 1, 2'b10, 32'h4000, 1, 0, 0, 32'h3000, 1, 2'd1));
    tbl.push_back(mk("rs_snd",  1, 2'b00, 32'h0000, 1, 32'h8000, 1, 1, 0, 32'h1004, 1, 2'b00, 32'h1004, 0, 0, 1, 32'h4000, 1, 2'd1));
    tbl.push_back(mk("rs_rf1",  1, 2'b00, 32'h0000, 1, 32'h8000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'h4000, 0, 2'd2));
    tbl.push_back(mk("rs_rf2",  1, 2'b00, 32'h0000, 1, 32'h8000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'h4000, 0, 2'd2));
    tbl.push_back(mk("int_T",   1, 2'b00, 32'h0000, 1, 32'h8000, 1, 1, 0, 32'h1004, 0, 2'b10, 32'h8000, 1, 1, 0, 32'h4000, 0, 2'd0));
    tbl.push_back(mk("int_snd", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 1, 32'h8000, 1, 2'd1));
    tbl.push_back(mk("int_acc", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 1, 2'b00, 32'h1004, 0, 0, 1, 32'h8000, 1, 2'd1));
    tbl.push_back(mk("int_rf1", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'h8000, 0, 2'd2));
    // reset mid-REFILL and mid-SEND
    tbl.push_back(mk("rst_rf",  0, 2'b11, 32'h6000, 1, 32'h8000, 1, 1, 0, 32'h1004, 1, 2'b00, 32'h1004, 0, 0, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("rst_rel", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b01, 32'h1004, 0, 0, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("wb7_T",   1, 2'b11, 32'h7000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b10, 32'h7000, 1, 0, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("rst_snd", 0, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 1, 2'b00, 32'h1004, 0, 0, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("rst_rl2", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 1, 2'b01, 32'h1004, 0, 0, 0, 32'h0000, 0, 2'd0));
    // plain interrupt from IDLE, full round trip
    tbl.push_back(mk("i9_T",    1, 2'b00, 32'h0000, 1, 32'h9000, 1, 1, 0, 32'h1004, 0, 2'b10, 32'h9000, 1, 1, 0, 32'h0000, 0, 2'd0));
    tbl.push_back(mk("i9_snd",  1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 1, 32'h9000, 1, 2'd1));
    tbl.push_back(mk("i9_acc",  1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 1, 2'b00, 32'h1004, 0, 0, 1, 32'h9000, 1, 2'd1));
    tbl.push_back(mk("i9_rf1",  1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'h9000, 0, 2'd2));
    tbl.push_back(mk("i9_rf2",  1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'h9000, 0, 2'd2));
    tbl.push_back(mk("i9_idle", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b01, 32'h1004, 0, 0, 0, 32'h9000, 0, 2'd0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Redirect under a random amount of backpressure; offer must hold until accepted.
    k = $urandom_range(0, 5);
    apply(mk("h_T",   1, 2'b11, 32'hA000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b10, 32'hA000, 1, 0, 0, 32'h9000, 0, 2'd0));
    for (int i = 0; i < k; i++)
      apply(mk("h_bp",  1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 1, 32'hA000, 1, 2'd1));
    apply(mk("h_acc", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 1, 2'b00, 32'h1004, 0, 0, 1, 32'hA000, 1, 2'd1));
    for (int i = 0; i < RC; i++)
      apply(mk("h_rf",  1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b00, 32'h1004, 0, 0, 0, 32'hA000, 0, 2'd2));
    apply(mk("h_idle", 1, 2'b00, 32'h0000, 0, 32'h0000, 1, 1, 0, 32'h1004, 0, 2'b01, 32'h1004, 0, 0, 0, 32'hA000, 0, 2'd0));

    @(posedge clk);
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
